// File: rtl/uart_boot_dma.sv
// rtl/uart_boot_dma.sv - UART boot loader: assembles LE words, streams program, then forwards data words
module uart_boot_dma #(
    parameter int          MAX_INSTR = 1024,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA,
    parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    input  logic        rx_ferr,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  sdata,
    output logic        instr_ready,
    output logic        mem_ready,
    output logic [31:0] data,
    output logic        program_loaded,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {S_SIZE, S_CODE, S_ACK, S_ERR, S_RUN} state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] shift_reg;
    logic [31:0] word_cnt;
    logic        accept;
    logic [31:0] word;

    assign accept = rx_ready && !rx_ferr &&
                    (state == S_SIZE || state == S_CODE || state == S_RUN);
    // Bytes 0..2 sit in shift_reg; the incoming byte completes the word.
    assign word   = {rdata, shift_reg};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_SIZE;
            byte_idx       <= 2'd0;
            shift_reg      <= 24'd0;
            word_cnt       <= 32'd0;
            tx_start       <= 1'b0;
            sdata          <= 8'd0;
            instr_ready    <= 1'b0;
            mem_ready      <= 1'b0;
            data           <= 32'd0;
            program_loaded <= 1'b0;
            instr_count    <= 32'd0;
        end else begin
            instr_ready <= 1'b0;
            mem_ready   <= 1'b0;
            tx_start    <= 1'b0;

            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: shift_reg[7:0]   <= rdata;
                    2'd1: shift_reg[15:8]  <= rdata;
                    2'd2: shift_reg[23:16] <= rdata;
                    default: begin
                        data <= word;
                        case (state)
                            S_SIZE: begin
                                instr_count <= word;
                                word_cnt    <= 32'd0;
                                if (word == 32'd0)
                                    state <= S_ACK;
                                else if (word > 32'(MAX_INSTR))
                                    state <= S_ERR;
                                else
                                    state <= S_CODE;
                            end
                            S_CODE: begin
                                instr_ready <= 1'b1;
                                word_cnt    <= word_cnt + 32'd1;
                                if (word_cnt + 32'd1 == instr_count)
                                    state <= S_ACK;
                            end
                            default: mem_ready <= 1'b1;
                        endcase
                    end
                endcase
            end

            case (state)
                S_ACK: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    sdata    <= ACK_BYTE;
                    state    <= S_RUN;
                end
                S_ERR: if (!tx_busy) begin
                    tx_start    <= 1'b1;
                    sdata       <= ERR_BYTE;
                    instr_count <= 32'd0;
                    state       <= S_SIZE;
                end
                S_RUN: program_loaded <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_dma.sv
// tb/tb_uart_boot_dma.sv - randomized bench for uart_boot_dma against a word-level reference model
module tb_uart_boot_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rdata = 8'd0;
    logic        rx_ferr = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        instr_ready;
    logic        mem_ready;
    logic [31:0] data;
    logic        program_loaded;
    logic [31:0] instr_count;

    uart_boot_dma dut (
        .clock(clock), .reset(reset), .rx_ready(rx_ready), .rdata(rdata),
        .rx_ferr(rx_ferr), .tx_busy(tx_busy), .tx_start(tx_start), .sdata(sdata),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .data(data),
        .program_loaded(program_loaded), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] instr_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_mem[$];
    int          tx_cnt = 0;
    logic [7:0]  tx_last = 8'd0;
    int          both_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (instr_ready) instr_q.push_back(data);
            if (mem_ready)   mem_q.push_back(data);
            if (tx_start) begin
                tx_cnt++;
                tx_last = sdata;
            end
            if (instr_ready && mem_ready) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic clear_obs();
        instr_q.delete(); mem_q.delete(); exp_instr.delete(); exp_mem.delete();
        tx_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; rx_ready = 1'b0; rx_ferr = 1'b0; tx_busy = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        rx_ready = 1'b1; rdata = b; rx_ferr = ferr;
        @(negedge clock);
        rx_ready = 1'b0; rx_ferr = 1'b0;
    endtask

    // kind: 0 = no strobe expected, 1 = instr_ready, 2 = mem_ready
    task automatic send_word(input logic [31:0] w, input int kind, input bit noisy);
        for (int k = 0; k < 4; k++) begin
            if (noisy && $urandom_range(0, 3) == 0)
                send_byte(8'($urandom), 1'b1);
            send_byte(8'((w >> (8 * k)) & 32'hFF), 1'b0);
        end
        check("strobe_latency", {30'd0, mem_ready, instr_ready},
              (kind == 1) ? 32'd1 : (kind == 2) ? 32'd2 : 32'd0);
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp_byte);
        int n = 0;
        while (!tx_start && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_tx_seen"}, {31'd0, tx_start}, 32'd1);
        check({tag, "_sdata"}, {24'd0, sdata}, {24'd0, exp_byte});
        @(negedge clock);
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_instr_n"}, instr_q.size(), exp_instr.size());
        for (int i = 0; i < exp_instr.size() && i < instr_q.size(); i++)
            check({tag, "_instr_w"}, instr_q[i], exp_instr[i]);
        check({tag, "_mem_n"}, mem_q.size(), exp_mem.size());
        for (int i = 0; i < exp_mem.size() && i < mem_q.size(); i++)
            check({tag, "_mem_w"}, mem_q[i], exp_mem[i]);
    endtask

    task automatic boot(input string tag, input logic [31:0] prog[$], input bit noisy);
        send_word(prog.size(), 0, noisy);
        check({tag, "_instr_count"}, instr_count, prog.size());
        foreach (prog[i]) begin
            exp_instr.push_back(prog[i]);
            send_word(prog[i], 1, noisy);
        end
        wait_tx(tag, 8'hAA);
        @(negedge clock);
        check({tag, "_loaded"}, {31'd0, program_loaded}, 32'd1);
    endtask

    logic [31:0] prog[$];
    logic [31:0] w;
    int          tx_before;

    initial begin
        do_reset();
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_sdata", {24'd0, sdata}, 32'd0);
        check("rst_strobes", {30'd0, instr_ready, mem_ready}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_loaded", {31'd0, program_loaded}, 32'd0);
        check("rst_count", instr_count, 32'd0);

        prog = '{32'h00000013, 32'h00001337};
        boot("boot1", prog, 1'b0);
        check("boot1_tx_cnt", tx_cnt, 32'd1);
        tx_before = tx_cnt;
        exp_mem.push_back(32'h04030201);
        send_word(32'h04030201, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            exp_mem.push_back(w);
            send_word(w, 2, 1'b1);
        end
        // dropped byte mid-word: 11, 22(ferr), 33, 44, 55
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0);
        exp_mem.push_back(32'h55443311);
        check("ferr_word_strobe", {31'd0, mem_ready}, 32'd1);
        repeat (3) @(negedge clock);
        check("run_no_tx", tx_cnt, tx_before);
        compare_queues("run");

        do_reset();
        send_word(32'd1025, 0, 1'b0);
        wait_tx("err1025", 8'hEE);
        check("err_count_clr", instr_count, 32'd0);
        check("err_not_loaded", {31'd0, program_loaded}, 32'd0);
        send_word(32'hFFFFFFFF, 0, 1'b0);
        wait_tx("err_max", 8'hEE);
        send_word(32'd1024, 0, 1'b0);
        check("max_ok_count", instr_count, 32'd1024);
        do_reset();
        send_word(32'd0, 0, 1'b0);
        wait_tx("len0", 8'hAA);
        @(negedge clock);
        check("len0_loaded", {31'd0, program_loaded}, 32'd1);
        compare_queues("len0");

        do_reset();
        tx_busy = 1'b1;
        prog = '{$urandom, $urandom, $urandom};
        send_word(32'd3, 0, 1'b0);
        foreach (prog[i]) begin
            exp_instr.push_back(prog[i]);
            send_word(prog[i], 1, 1'b0);
        end
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        repeat (50 - 16) @(negedge clock);
        check("busy_no_tx", tx_cnt, 32'd0);
        tx_busy = 1'b0;
        @(negedge clock);
        check("busy_release_tx", {31'd0, tx_start}, 32'd1);
        check("busy_release_sdata", {24'd0, sdata}, 32'hAA);
        repeat (10) @(negedge clock);
        check("busy_tx_once", tx_cnt, 32'd1);
        compare_queues("busy");

        do_reset();
        send_word(32'd2, 0, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_outs", {tx_start, instr_ready, mem_ready, program_loaded}, 32'd0);
        check("midrst_data", data, 32'd0);
        check("midrst_count", instr_count, 32'd0);
        clear_obs();
        prog = '{32'h00000013, 32'h00001337};
        boot("reboot", prog, 1'b0);
        compare_queues("reboot");

        for (int it = 0; it < 4; it++) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) prog.push_back($urandom);
            boot("rnd", prog, 1'b1);
            for (int i = 0; i < 3; i++) begin
                w = $urandom;
                exp_mem.push_back(w);
                send_word(w, 2, 1'b1);
            end
            @(negedge clock);
            compare_queues("rnd");
            check("rnd_tx_cnt", tx_cnt, 32'd1);
        end

        check("never_both_strobes", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
